// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding and frame constants.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } rx_state_e;

  localparam int         HDR_BITS   = 8;
  localparam logic [3:0] CMD_REPORT = 4'b1110;

endpackage

// File: rtl/rx_shift8.sv
// MSB-first 8-bit deserializer with a 3-bit bit counter; shared by header and payload.
module rx_shift8
  import serial_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] word,
  output logic       last,
  output logic       partial
);

  localparam logic [2:0] LAST_BIT = 3'(HDR_BITS - 1);

  logic [6:0] sr;
  logic [2:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[5:0], bit_in};
      cnt <= cnt + 3'd1;
    end
  end

  // word includes the bit being accepted, so it is complete in the cycle last is high
  assign word    = {sr, bit_in};
  assign last    = shift_en && (cnt == LAST_BIT);
  assign partial = (cnt != 3'd0);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: header byte (CRC_M/CMD) followed by payload bytes, with
// end-of-frame init/frame_err. Define FRAME_RX_STATS_EN to add good_cnt/err_cnt.
//
// Handshake: a bit is accepted only in HDR/PAY when rx_frame && rx_valid; there is
// no backpressure. enable/data_in, byte_valid, init and frame_err are 1-cycle pulses.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int MAX_BYTES = 16
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       rx_frame,
  input  logic       rx_valid,
  input  logic       rx_data,
  output logic       enable,
  output logic       data_in,
  output logic [3:0] CRC_M,
  output logic [3:0] CMD,
  output logic       init,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [4:0] byte_cnt,
  output logic       frame_err,
  output logic [1:0] state_dbg
`ifdef FRAME_RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

  rx_state_e  state;
  logic       armed;
  logic       overflow;
  logic       accept;
  logic [7:0] sh_word;
  logic       sh_last;
  logic       sh_partial;

  assign accept    = ((state == HDR) || (state == PAY)) && rx_frame && rx_valid;
  assign state_dbg = state;

  rx_shift8 u_shift (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .clr       (state == IDLE),
    .shift_en  (accept),
    .bit_in    (rx_data),
    .word      (sh_word),
    .last      (sh_last),
    .partial   (sh_partial)
  );

  // armed stays low after reset until rx_frame has been seen low, so a frame
  // that was in flight across reset is never picked up half way through
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      overflow   <= 1'b0;
      enable     <= 1'b0;
      data_in    <= 1'b0;
      CRC_M      <= '0;
      CMD        <= '0;
      init       <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_cnt   <= '0;
      frame_err  <= 1'b0;
    end else begin
      enable     <= accept;
      data_in    <= accept & rx_data;
      byte_valid <= 1'b0;
      init       <= 1'b0;
      frame_err  <= 1'b0;
      armed      <= armed | ~rx_frame;
      case (state)
        IDLE: begin
          if (rx_frame && armed) begin
            state    <= HDR;
            byte_cnt <= '0;
            overflow <= 1'b0;
          end
        end
        HDR: begin
          if (!rx_frame) begin
            state     <= DONE;
            init      <= 1'b1;
            frame_err <= 1'b1;
          end else if (sh_last) begin
            state <= PAY;
            CRC_M <= sh_word[7:4];
            CMD   <= sh_word[3:0];
          end
        end
        PAY: begin
          if (!rx_frame) begin
            state     <= DONE;
            init      <= 1'b1;
            frame_err <= overflow | sh_partial;
          end else if (sh_last) begin
            if (byte_cnt == MAX_CNT) begin
              overflow <= 1'b1;
            end else begin
              byte_data  <= sh_word;
              byte_valid <= 1'b1;
              byte_cnt   <= byte_cnt + 5'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_RX_STATS_EN
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else if (init) begin
      if (frame_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized scoreboard bench for serial_frame_rx (MAX_BYTES=2).
module tb_serial_frame_rx;

  localparam int MAXB = 2;

  logic       sys_clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       rx_frame = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_data = 1'b0;
  logic       enable, data_in, init, byte_valid, frame_err;
  logic [3:0] CRC_M, CMD;
  logic [7:0] byte_data;
  logic [4:0] byte_cnt;
  logic [1:0] state_dbg;
`ifdef FRAME_RX_STATS_EN
  logic [15:0] good_cnt, err_cnt;
`endif

  serial_frame_rx #(.MAX_BYTES(MAXB)) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .rx_frame   (rx_frame),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .enable     (enable),
    .data_in    (data_in),
    .CRC_M      (CRC_M),
    .CMD        (CMD),
    .init       (init),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_cnt   (byte_cnt),
    .frame_err  (frame_err),
    .state_dbg  (state_dbg)
`ifdef FRAME_RX_STATS_EN
    ,
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  logic [0:0]  exp_bit_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [21:0] exp_frm_q[$];   // {crc_m, cmd, err, byte_cnt, enables}

  logic [3:0] m_crc = '0;
  logic [3:0] m_cmd = '0;
  int         m_good = 0;
  int         m_err = 0;
  bit         prev_short = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input logic f, input logic v, input logic d);
    rx_frame = f;
    rx_valid = v;
    rx_data  = d;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Sends one frame: first-sent payload bit is pay[pay_bits-1]. The model follows
  // the frame rules: header MSB first, bytes counted only up to MAXB, error on a
  // short header, a partial byte, or more than MAXB bytes.
  task automatic send_frame(input logic [7:0] hdr, input int hdr_bits,
                            input logic [255:0] pay, input int pay_bits,
                            input bit fall_valid, input bit short_gap);
    int   total, j, nbytes, cnt, lead;
    logic b, err;
    total = hdr_bits + pay_bits;
    lead  = prev_short ? 2 : 1;
    repeat (lead) cyc(1'b1, rbit(), rbit());
    for (int i = 0; i < total; i++) begin
      if (i < hdr_bits) b = hdr[7-i];
      else              b = pay[pay_bits-1-(i-hdr_bits)];
      repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, rbit());
      exp_bit_q.push_back(b);
      if (i >= hdr_bits) begin
        j = i - hdr_bits;
        if ((j % 8 == 7) && (j / 8 < MAXB)) exp_byte_q.push_back(pay[pay_bits-1-8*(j/8) -: 8]);
      end
      cyc(1'b1, 1'b1, b);
    end
    if (hdr_bits == 8) begin
      m_crc = hdr[7:4];
      m_cmd = hdr[3:0];
    end
    nbytes = pay_bits / 8;
    err    = (hdr_bits < 8) || (pay_bits % 8 != 0) || (nbytes > MAXB);
    cnt    = (nbytes > MAXB) ? MAXB : nbytes;
    if (err) m_err++; else m_good++;
    exp_frm_q.push_back({m_crc, m_cmd, err, 5'(cnt), 8'(total)});
    cyc(1'b0, fall_valid, rbit());
    if (!short_gap) repeat ($urandom_range(1, 3)) cyc(1'b0, rbit(), rbit());
    prev_short = short_gap;
  endtask

  // scoreboard monitor
  int en_cnt = 0;
  always @(negedge sys_clk) begin
    logic [21:0] e;
    if (sys_reset) begin
      en_cnt = 0;
    end else begin
      if (init) begin
        if (exp_frm_q.size() == 0) begin
          check("init_unexpected", 32'(init), 32'd0);
        end else begin
          e = exp_frm_q.pop_front();
          check("frame_crc_m", 32'(CRC_M), 32'(e[21:18]));
          check("frame_cmd", 32'(CMD), 32'(e[17:14]));
          check("frame_err", 32'(frame_err), 32'(e[13]));
          check("frame_byte_cnt", 32'(byte_cnt), 32'(e[12:8]));
          check("frame_enables", 32'(en_cnt), 32'(e[7:0]));
        end
        en_cnt = 0;
      end else begin
        check("frame_err_without_init", 32'(frame_err), 32'd0);
      end
      if (enable) begin
        en_cnt++;
        if (exp_bit_q.size() == 0) check("enable_unexpected", 32'(enable), 32'd0);
        else check("data_in", 32'(data_in), 32'(exp_bit_q.pop_front()));
      end
      if (byte_valid) begin
        check("byte_valid_with_enable", 32'(enable), 32'd1);
        if (exp_byte_q.size() == 0) check("byte_valid_unexpected", 32'(byte_valid), 32'd0);
        else check("byte_data", 32'(byte_data), 32'(exp_byte_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, 32'(enable), 32'd0);
    check({tag, "_data_in"}, 32'(data_in), 32'd0);
    check({tag, "_init"}, 32'(init), 32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_crc_m"}, 32'(CRC_M), 32'd0);
    check({tag, "_cmd"}, 32'(CMD), 32'd0);
    check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    check({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    logic [7:0]   hdr;
    logic [255:0] pay;
    int           hb, pb;
    sys_reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    sys_reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // header only, valid high on the falling edge of the frame
    send_frame(8'hA5, 8, '0, 0, 1'b1, 1'b0);
    // one payload byte, CMD=E held through init
    send_frame(8'h3E, 8, 256'hC3, 8, 1'b0, 1'b0);
    // 11 payload bits
    pay = 256'($urandom);
    send_frame(8'h71, 8, pay, 11, 1'b1, 1'b0);
    // 3 bytes into a 2-byte receiver
    send_frame(8'h9C, 8, 256'h5AC396, 24, 1'b0, 1'b0);
    // incomplete header keeps previous CRC_M/CMD
    send_frame(8'hF0, 5, '0, 0, 1'b1, 1'b0);
    // back-to-back frames with the minimum gap; bits during DONE/IDLE ignored
    send_frame(8'h12, 8, 256'hBEEF, 16, 1'b1, 1'b1);
    send_frame(8'h34, 8, 256'h77, 8, 1'b1, 1'b0);

    // reset after 5 header bits
    cyc(1'b1, 1'b0, 1'b0);
    hdr = 8'hC6;
    for (int i = 0; i < 5; i++) begin
      exp_bit_q.push_back(hdr[7-i]);
      cyc(1'b1, 1'b1, hdr[7-i]);
    end
    cyc(1'b1, 1'b0, 1'b0);
    sys_reset = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    m_crc = '0;
    m_cmd = '0;
    m_good = 0;
    m_err = 0;
    @(posedge sys_clk);
    #1;
    repeat (2) cyc(1'b1, 1'b1, rbit());
    sys_reset = 1'b0;
    // frame still high after release: must not be picked up
    repeat (4) cyc(1'b1, 1'b1, rbit());
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    prev_short = 1'b0;
    send_frame(8'h5A, 8, '0, 0, 1'b0, 1'b0);

    // randomized frames
    for (int n = 0; n < 25; n++) begin
      hdr = 8'($urandom);
      hb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : 8;
      pb  = (hb == 8) ? int'($urandom_range(0, 28)) : 0;
      pay = 256'($urandom);
      send_frame(hdr, hb, pay, pb, rbit(), ($urandom_range(0, 3) == 0));
    end

    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    check("bits_left", 32'(exp_bit_q.size()), 32'd0);
    check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    check("frames_left", 32'(exp_frm_q.size()), 32'd0);
`ifdef FRAME_RX_STATS_EN
    check("good_cnt", 32'(good_cnt), 32'(m_good));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
